// File: rtl/dice_roll_monitor.sv
// dice_roll_monitor: consumer side of the electronic dice interface.
// Watches button/throw, waits a settle window after the button is released,
// captures the final face and offers it on a valid/ready handshake.
// Keeps saturating per-face and total statistics, readable via a registered
// face-select port, plus sticky illegal-face and overrun flags.
// Optional: define DICE_MON_BUTTON_SYNC_EN to pass the button through a
// two-flop synchroniser (adds two cycles to every button-driven transition).

module dice_roll_monitor #(
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [2:0]       throw,
  input  logic             clear,
  input  logic             result_ready,
  output logic [2:0]       result,
  output logic             result_valid,
  output logic             rolling,
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] sel_count,
  output logic [CNT_W+2:0] total,
  output logic             err,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, ROLLING, SETTLE, HOLD} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [2:0]       result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             rolling_q, rolling_d;
  logic             err_q, err_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W+2:0] total_q, total_d;
  logic [CNT_W-1:0] sel_count_q, sel_count_d;
  logic [CNT_W-1:0] face_cnt_q [1:6];
  logic [CNT_W-1:0] face_cnt_d [1:6];

  logic btn;
  logic legal;
  logic capture;
  logic accept;
  logic drop;

`ifdef DICE_MON_BUTTON_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Shift the raw button pin into the two-stage synchroniser.
  always_comb begin
    sync_d = {sync_q[0], button};
  end

  // Synchroniser flops; both clear to 0 so no roll is seen out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= sync_d;
  end

  assign btn = sync_q[1];
`else
  assign btn = button;
`endif

  assign legal = (throw != 3'd0) && (throw != 3'd7);

  // State register for the roll-tracking FSM and its settle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      settle_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic: follow the button through a roll and decide when to capture.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    capture  = 1'b0;
    accept   = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn) state_d = ROLLING;
      end
      ROLLING: begin
        if (!btn) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (btn) begin
          state_d = ROLLING;
        end else if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = legal ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (result_valid_q && result_ready) begin
          accept  = 1'b1;
          state_d = btn ? ROLLING : IDLE;
        end else if (btn) begin
          drop    = 1'b1;
          state_d = ROLLING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: capture, handshake, statistics and sticky flags.
  always_comb begin
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_d          = err_q;
    overrun_d      = overrun_q;
    total_d        = total_q;
    face_cnt_d     = face_cnt_q;
    sel_count_d    = '0;
    rolling_d      = (state_d == ROLLING) || (state_d == SETTLE);

    for (int i = 1; i <= 6; i++) begin
      if (sel == 3'(i)) sel_count_d = face_cnt_q[i];
    end

    if (capture && legal) begin
      result_d       = throw;
      result_valid_d = 1'b1;
      for (int i = 1; i <= 6; i++) begin
        if ((throw == 3'(i)) && (face_cnt_q[i] != '1)) begin
          face_cnt_d[i] = face_cnt_q[i] + 1'b1;
        end
      end
      if (total_q != '1) total_d = total_q + 1'b1;
    end

    if (capture && !legal) err_d = 1'b1;

    if (accept || drop) result_valid_d = 1'b0;
    if (drop)           overrun_d      = 1'b1;

    if (clear) begin
      for (int i = 1; i <= 6; i++) face_cnt_d[i] = '0;
      total_d   = '0;
      err_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Registered outputs and statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q       <= 3'd0;
      result_valid_q <= 1'b0;
      rolling_q      <= 1'b0;
      err_q          <= 1'b0;
      overrun_q      <= 1'b0;
      total_q        <= '0;
      sel_count_q    <= '0;
      for (int i = 1; i <= 6; i++) face_cnt_q[i] <= '0;
    end else begin
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      rolling_q      <= rolling_d;
      err_q          <= err_d;
      overrun_q      <= overrun_d;
      total_q        <= total_d;
      sel_count_q    <= sel_count_d;
      for (int i = 1; i <= 6; i++) face_cnt_q[i] <= face_cnt_d[i];
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign rolling      = rolling_q;
  assign err          = err_q;
  assign overrun      = overrun_q;
  assign total        = total_q;
  assign sel_count    = sel_count_q;

endmodule

// File: tb/tb_dice_roll_monitor.sv
// tb_dice_roll_monitor: directed scenarios plus randomized rolls for
// dice_roll_monitor, checked every cycle against a roll-level reference model.
// Two instances share the stimulus: default widths and CNT_W=2 for saturation.
// Honours DICE_MON_BUTTON_SYNC_EN by delaying the model's view of the button.

module tb_dice_roll_monitor;

  localparam int SETTLE_CYC = 2;
`ifdef DICE_MON_BUTTON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst_drv = 1'b1;
  logic       button = 1'b0;
  logic [2:0] throw_in = 3'd0;
  logic       clear = 1'b0;
  logic       result_ready = 1'b0;
  logic [2:0] sel = 3'd0;

  logic [2:0]  result, result_s;
  logic        result_valid, result_valid_s;
  logic        rolling, rolling_s;
  logic [7:0]  sel_count;
  logic [1:0]  sel_count_s;
  logic [10:0] total;
  logic [4:0]  total_s;
  logic        err, err_s;
  logic        overrun, overrun_s;

  int errors = 0;
  int checks = 0;

  dice_roll_monitor #(.CNT_W(8), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst(rst), .button(button), .throw(throw_in), .clear(clear),
    .result_ready(result_ready), .result(result), .result_valid(result_valid),
    .rolling(rolling), .sel(sel), .sel_count(sel_count), .total(total),
    .err(err), .overrun(overrun)
  );

  dice_roll_monitor #(.CNT_W(2), .SETTLE_CYC(SETTLE_CYC)) dut_sat (
    .clk(clk), .rst(rst), .button(button), .throw(throw_in), .clear(clear),
    .result_ready(result_ready), .result(result_s), .result_valid(result_valid_s),
    .rolling(rolling_s), .sel(sel), .sel_count(sel_count_s), .total(total_s),
    .err(err_s), .overrun(overrun_s)
  );

  always #5 clk = ~clk;

  // Reference model: a roll is "in progress" from the first high button sample
  // until the face is taken on the (SETTLE_CYC+1)-th consecutive low sample.
  // Statistics are kept as unbounded tallies; saturation is applied on compare.
  bit   m_in_roll = 0;
  int   m_low_run = 0;
  bit   m_pending = 0;
  int   m_result = 0;
  bit   m_err = 0;
  bit   m_overrun = 0;
  int   raw [1:6] = '{0, 0, 0, 0, 0, 0};
  int   raw_total = 0;
  int   m_sel_raw = 0;
  logic b1 = 1'b0, b2 = 1'b0;

  function automatic int sat(input int v, input int cap);
    return (v > cap) ? cap : v;
  endfunction

  task automatic model_reset();
    m_in_roll = 0; m_low_run = 0; m_pending = 0; m_result = 0;
    m_err = 0; m_overrun = 0; raw_total = 0; m_sel_raw = 0;
    for (int i = 1; i <= 6; i++) raw[i] = 0;
    b1 = 1'b0; b2 = 1'b0;
  endtask

  task automatic model_step();
    logic ub;
    int   s_i, t_i, inc_face, next_sel;
    bit   err_set, ov_set;
    ub = (LAT == 2) ? b2 : button;
    s_i = int'(sel);
    t_i = int'(throw_in);
    inc_face = 0; err_set = 0; ov_set = 0;
    next_sel = (s_i >= 1 && s_i <= 6) ? raw[s_i] : 0;
    if (m_pending) begin
      if (result_ready) begin
        m_pending = 0;
        if (ub) begin m_in_roll = 1; m_low_run = 0; end
      end else if (ub) begin
        m_pending = 0; ov_set = 1; m_in_roll = 1; m_low_run = 0;
      end
    end else if (!m_in_roll) begin
      if (ub) begin m_in_roll = 1; m_low_run = 0; end
    end else if (ub) begin
      m_low_run = 0;
    end else begin
      m_low_run++;
      if (m_low_run == SETTLE_CYC + 1) begin
        m_in_roll = 0;
        if (t_i >= 1 && t_i <= 6) begin
          m_result = t_i; m_pending = 1; inc_face = t_i;
        end else begin
          err_set = 1;
        end
      end
    end
    if (clear) begin
      for (int i = 1; i <= 6; i++) raw[i] = 0;
      raw_total = 0; m_err = 0; m_overrun = 0;
    end else begin
      if (inc_face != 0) begin raw[inc_face]++; raw_total++; end
      if (err_set) m_err = 1;
      if (ov_set) m_overrun = 1;
    end
    m_sel_raw = next_sel;
    b2 = b1;
    b1 = button;
  endtask

  // Advance the model on every active edge, or reset it with the DUTs.
  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("result", int'(result), m_result);
    checkOutput("result_valid", int'(result_valid), int'(m_pending));
    checkOutput("rolling", int'(rolling), int'(m_in_roll));
    checkOutput("err", int'(err), int'(m_err));
    checkOutput("overrun", int'(overrun), int'(m_overrun));
    checkOutput("sel_count", int'(sel_count), sat(m_sel_raw, 255));
    checkOutput("total", int'(total), sat(raw_total, 2047));
    checkOutput("sat.result", int'(result_s), m_result);
    checkOutput("sat.result_valid", int'(result_valid_s), int'(m_pending));
    checkOutput("sat.rolling", int'(rolling_s), int'(m_in_roll));
    checkOutput("sat.err", int'(err_s), int'(m_err));
    checkOutput("sat.overrun", int'(overrun_s), int'(m_overrun));
    checkOutput("sat.sel_count", int'(sel_count_s), sat(m_sel_raw, 3));
    checkOutput("sat.total", int'(total_s), sat(raw_total, 31));
  end

  // Drive one cycle of inputs just after the falling edge, return at the next one.
  task automatic applyStimulus(input logic b, input logic [2:0] t, input logic rr,
                               input logic c, input logic [2:0] s);
    #1;
    rst = rst_drv;
    button = b; throw_in = t; result_ready = rr; clear = c; sel = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_roll(input logic [2:0] face, input bit accept_it);
    repeat (2) applyStimulus(1'b1, face, 1'b0, 1'b0, 3'd0);
    repeat (SETTLE_CYC + 1 + LAT) applyStimulus(1'b0, face, 1'b0, 1'b0, 3'd0);
    if (accept_it) applyStimulus(1'b0, face, 1'b1, 1'b0, 3'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset.result", int'(result), 0);
    checkOutput("reset.valid", int'(result_valid), 0);
    checkOutput("reset.total", int'(total), 0);
    applyStimulus(1'b0, 3'd4, 1'b0, 1'b0, 3'd0);

    // First roll: face 4, button high five cycles, then released.
    repeat (5) applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 3'd4);
    checkOutput("s1.rolling_high", int'(rolling), 1);
    repeat (SETTLE_CYC + LAT) applyStimulus(1'b0, 3'd4, 1'b0, 1'b0, 3'd4);
    checkOutput("s1.no_early_capture", int'(result_valid), 0);
    applyStimulus(1'b0, 3'd4, 1'b0, 1'b0, 3'd4);
    checkOutput("s1.valid", int'(result_valid), 1);
    checkOutput("s1.result", int'(result), 4);
    checkOutput("s1.total", int'(total), 1);
    checkOutput("s1.rolling_low", int'(rolling), 0);
    applyStimulus(1'b0, 3'd4, 1'b0, 1'b0, 3'd4);
    checkOutput("s1.count4", int'(sel_count), 1);
    applyStimulus(1'b0, 3'd4, 1'b1, 1'b0, 3'd4);
    checkOutput("s1.accepted", int'(result_valid), 0);
    checkOutput("s1.result_held", int'(result), 4);

    // Several accepted rolls after a clear.
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b1, 3'd0);
    do_roll(3'd1, 1); do_roll(3'd2, 1); do_roll(3'd3, 1);
    do_roll(3'd6, 1); do_roll(3'd6, 1);
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 3'd6);
    checkOutput("s2.count6", int'(sel_count), 2);
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 3'd5);
    checkOutput("s2.count5", int'(sel_count), 0);
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 3'd7);
    checkOutput("s2.sel7", int'(sel_count), 0);
    checkOutput("s2.total", int'(total), 5);

    // Illegal face at capture, then clear.
    do_roll(3'd7, 0);
    checkOutput("s3.err", int'(err), 1);
    checkOutput("s3.valid", int'(result_valid), 0);
    checkOutput("s3.total", int'(total), 5);
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b1, 3'd6);
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 3'd6);
    checkOutput("s3.err_cleared", int'(err), 0);
    checkOutput("s3.total_cleared", int'(total), 0);
    checkOutput("s3.count6_cleared", int'(sel_count), 0);

    // Overrun: new roll while the result is still pending.
    do_roll(3'd5, 0);
    checkOutput("s4.pending", int'(result_valid), 1);
    repeat (1 + LAT) applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
    checkOutput("s4.overrun", int'(overrun), 1);
    checkOutput("s4.dropped", int'(result_valid), 0);
    checkOutput("s4.rolling", int'(rolling), 1);
    repeat (SETTLE_CYC + 1 + LAT) applyStimulus(1'b0, 3'd5, 1'b0, 1'b0, 3'd0);
    checkOutput("s4.recapture", int'(result_valid), 1);
    applyStimulus(1'b0, 3'd5, 1'b1, 1'b0, 3'd0);

    // Glitch during settle: brief release then re-press.
    repeat (2) applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 3'd0);
    repeat (1 + LAT) applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 3'd0);
    checkOutput("s5.no_capture", int'(result_valid), 0);
    checkOutput("s5.still_rolling", int'(rolling), 1);
    repeat (SETTLE_CYC + 1 + LAT) applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 3'd0);
    checkOutput("s5.capture", int'(result), 2);
    applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 3'd0);

    // Saturation on the narrow instance.
    applyStimulus(1'b0, 3'd3, 1'b0, 1'b1, 3'd0);
    repeat (5) do_roll(3'd3, 1);
    applyStimulus(1'b0, 3'd3, 1'b0, 1'b0, 3'd3);
    checkOutput("s6.sat_count3", int'(sel_count_s), 3);
    checkOutput("s6.wide_count3", int'(sel_count), 5);
    checkOutput("s6.sat_total", int'(total_s), 5);

    // Asynchronous reset in the middle of a HOLD cycle.
    do_roll(3'd0, 0);
    do_roll(3'd2, 0);
    checkOutput("s7.hold_valid", int'(result_valid), 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("s7.result", int'(result), 0);
    checkOutput("s7.valid", int'(result_valid), 0);
    checkOutput("s7.err", int'(err), 0);
    checkOutput("s7.total", int'(total), 0);
    checkOutput("s7.rolling", int'(rolling), 0);
    @(negedge clk);
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 3'd0);

    // Randomized rolls with occasional clears and resets.
    for (int n = 0; n < 4000; n++) begin
      logic       b;
      logic [2:0] t;
      b = button;
      if ($urandom_range(0, 5) == 0) b = ~b;
      t = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7)
                                      : 3'($urandom_range(1, 6));
      rst_drv = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      applyStimulus(b, t, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0),
                    3'($urandom_range(0, 7)));
    end
    rst_drv = 1'b1;
    applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dice_roll_monitor.md
Name: dice_roll_monitor

Overview:
- Consumer side of the electronic dice interface. Watches the dice's `button` and `throw[2:0]` lines and detects the end of each roll.
- After a settle window, captures the final face and presents it downstream on a valid/ready handshake.
- Keeps saturating per-face and total roll statistics, readable through a registered select port.
- Sits between the dice and the display/scoring logic.

Parameters:
- CNT_W, 8, width of each per-face counter; total counter is CNT_W+3 bits.
- SETTLE_CYC, 2, cycles from button-release detection to capture; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- button  in  1  roll button, same signal that drives the dice.
- throw  in  3  dice face output; legal values 1..6.
- clear  in  1  synchronous clear of statistics and sticky flags.
- result_ready  in  1  downstream accepts result.
- result  out  3  captured face.
- result_valid  out  1  result pending.
- rolling  out  1  high while a roll is in progress (ROLLING or SETTLE).
- sel  in  3  face select for statistics read.
- sel_count  out  CNT_W  count for face sel, registered.
- total  out  CNT_W+3  total legal captures, saturating.
- err  out  1  sticky: illegal face (0 or 7) seen at capture.
- overrun  out  1  sticky: new roll started while a result was unaccepted.

Behaviour:
- Reset (rst=0, async): state IDLE; result=0, result_valid=0, rolling=0, err=0, overrun=0, all face counters=0, total=0, sel_count=0, settle counter=0.
- Let `btn` be the internal button signal (see Optional Feature).
- States: IDLE, ROLLING, SETTLE, HOLD. `rolling` is registered and equals (next state is ROLLING or SETTLE).
- IDLE:
  - btn=1 -> ROLLING.
- ROLLING:
  - btn=0 -> SETTLE; settle counter loaded with SETTLE_CYC-1.
- SETTLE:
  - btn=1 -> ROLLING; this is a glitch/re-press, no capture.
  - Else, counter>0 -> decrement.
  - Else capture throw. Capture edge is SETTLE_CYC cycles after the edge on which btn=0 was first sampled.
- Capture, legal throw (1..6):
  - result<=throw; result_valid<=1.
  - Counter[throw] and total increment, saturating at all-ones.
  - Next state HOLD.
- Capture, illegal throw (0 or 7):
  - err<=1; result_valid stays 0; no counter change; next state IDLE.
- HOLD:
  - result_valid=1 and result_ready=1 on an edge -> result_valid<=0, -> IDLE.
  - btn=1 while valid and not accepted on the same edge -> overrun<=1, result_valid<=0, result dropped, -> ROLLING.
  - Acceptance and btn=1 on the same edge -> accepted normally, no overrun, -> ROLLING.
- result holds its last captured value until the next legal capture.
- `sel_count` (one-cycle latency):
  - sel=1..6 -> sel_count<=counter[sel].
  - sel=0 or 7 -> 0.
  - Reflects counter values as of the previous edge.
- clear=1:
  - Face counters, total, err and overrun go to 0 on that edge.
  - Clear has priority over a same-edge increment or flag set.
  - A same-edge capture still updates result/result_valid.
  - No effect on the state machine.
- Reset mid-roll or mid-HOLD: immediate return to reset values; pending result lost.

Optional Feature:
- Macro: DICE_MON_BUTTON_SYNC_EN.
- Defined: button passes through a two-flop synchroniser (both flops reset to 0) before use. Every button-triggered transition is delayed by 2 cycles relative to the button pin, so capture occurs SETTLE_CYC+2 cycles after button falls.
- Undefined: `btn` is `button` directly; no added latency.

Test Plan:
- Defaults, throw held 4, button high 5 cycles then low -> `rolling` high during the roll; result=4 and result_valid=1 exactly 2 cycles after first low sample; counter[4]=1, total=1; result_ready=1 -> valid drops next edge.
- Rolls capturing 1,2,3,6,6 all accepted -> sel=6 gives sel_count=2 one cycle later; sel=5 gives 0; sel=7 gives 0; total=5.
- Illegal face: throw=7 at capture -> err=1, result_valid=0, total unchanged. Then clear=1 for one cycle -> err=0 and all counters 0.
- Overrun: result pending with result_ready=0, button rises -> overrun=1, result_valid=0, state ROLLING; next roll captures normally.
- Glitch in SETTLE: button low 1 cycle then high -> no capture, state ROLLING. Saturation: CNT_W=2 with five captures of face 3 -> counter[3]=3.
- Async reset asserted in HOLD mid-cycle -> all outputs 0 immediately. With DICE_MON_BUTTON_SYNC_EN defined, the first scenario captures 4 cycles after button falls.
